// File: rtl/level_round_timer.sv
// Per-level round timer: IDLE -> ARM countdown -> timed RUN -> DONE.
// Produces seconds remaining, per-second tick, round-over and system-clear pulses.
module level_round_timer #(
   parameter int unsigned CLKS_PER_TICK = 50000000,
   parameter int unsigned L1_SECS       = 30,
   parameter int unsigned L2_SECS       = 20,
   parameter int unsigned L3_SECS       = 10,
   parameter int unsigned ARM_TICKS     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] level,
   input  logic       level_reset,
   input  logic       start,
   input  logic       pause,
   output logic [1:0] state,
   output logic [5:0] secs_left,
   output logic [1:0] arm_left,
   output logic       tick,
   output logic       round_active,
   output logic       round_over,
   output logic       sys_clear
);

   localparam int unsigned PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          st_q, st_d;
   logic [1:0]      lvl_q, lvl_d;
   logic [5:0]      secs_d;
   logic [1:0]      arm_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick_d, over_d, clear_d;
   logic            terminal;

   function automatic logic [5:0] limit(input logic [1:0] l);
      case (l)
         2'd2:    return 6'(L2_SECS);
         2'd3:    return 6'(L3_SECS);
         default: return 6'(L1_SECS);
      endcase
   endfunction

   assign terminal = (presc_q == PRESC_LAST) && !pause;
   assign state    = st_q;

   always_comb begin
      st_d    = st_q;
      lvl_d   = lvl_q;
      secs_d  = secs_left;
      arm_d   = arm_left;
      presc_d = presc_q;
      tick_d  = 1'b0;
      over_d  = 1'b0;
      clear_d = 1'b0;

      // level_reset overrides everything, including a tick/round_over due this cycle
      if (level_reset) begin
         lvl_d   = (level == 2'd0) ? 2'd1 : level;
         st_d    = S_IDLE;
         secs_d  = limit(level);
         arm_d   = '0;
         presc_d = '0;
         clear_d = 1'b1;
      end else begin
         case (st_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  secs_d  = limit(lvl_q);
                  presc_d = '0;
                  if (ARM_TICKS > 0) begin
                     st_d  = S_ARM;
                     arm_d = 2'(ARM_TICKS);
                  end else begin
                     st_d = S_RUN;
                  end
               end
            end
            S_ARM: begin
               if (terminal) begin
                  presc_d = '0;
                  if (arm_left <= 2'd1) begin
                     st_d  = S_RUN;
                     arm_d = '0;
                  end else begin
                     arm_d = arm_left - 2'd1;
                  end
               end else if (!pause) begin
                  presc_d = presc_q + 1'b1;
               end
            end
            S_RUN: begin
               if (terminal) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  if (secs_left <= 6'd1) begin
                     secs_d = '0;
                     st_d   = S_DONE;
                     over_d = 1'b1;
                  end else begin
                     secs_d = secs_left - 6'd1;
                  end
               end else if (!pause) begin
                  presc_d = presc_q + 1'b1;
               end
            end
            default: st_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= S_IDLE;
         lvl_q        <= 2'd1;
         secs_left    <= 6'(L1_SECS);
         arm_left     <= '0;
         presc_q      <= '0;
         tick         <= 1'b0;
         round_active <= 1'b0;
         round_over   <= 1'b0;
         sys_clear    <= 1'b0;
      end else begin
         st_q         <= st_d;
         lvl_q        <= lvl_d;
         secs_left    <= secs_d;
         arm_left     <= arm_d;
         presc_q      <= presc_d;
         tick         <= tick_d;
         round_active <= (st_d == S_RUN);
         round_over   <= over_d;
         sys_clear    <= clear_d;
      end
   end

endmodule

// File: tb/tb_level_round_timer.sv
// Scoreboard bench for level_round_timer: stimulus queues expected pulse events,
// a negedge monitor matches every tick/round_over/sys_clear against the queue.
module tb_level_round_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] level;
   logic       level_reset, start, pause;
   logic [1:0] state;
   logic [5:0] secs_left;
   logic [1:0] arm_left;
   logic       tick, round_active, round_over, sys_clear;

   typedef struct {
      int unsigned cyc;
      logic        tk;
      logic        ro;
      logic        sc;
      logic [1:0]  st;
      logic [5:0]  secs;
   } ev_t;

   ev_t         exp_q[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned b;

   level_round_timer #(
      .CLKS_PER_TICK(4),
      .L1_SECS(3),
      .L2_SECS(2),
      .L3_SECS(1),
      .ARM_TICKS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .level(level),
      .level_reset(level_reset),
      .start(start),
      .pause(pause),
      .state(state),
      .secs_left(secs_left),
      .arm_left(arm_left),
      .tick(tick),
      .round_active(round_active),
      .round_over(round_over),
      .sys_clear(sys_clear)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int unsigned c, input logic tk, input logic ro,
                       input logic sc, input logic [1:0] st, input logic [5:0] s);
      ev_t e;
      e.cyc = c; e.tk = tk; e.ro = ro; e.sc = sc; e.st = st; e.secs = s;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_to(input int unsigned c);
      while (cyc < c) step(1);
   endtask

   // monitor: every output pulse must match the head of the expectation queue
   always @(negedge clk) begin
      if (!rst && (tick || round_over || sys_clear)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d tick=%b round_over=%b sys_clear=%b state=%0d secs=%0d",
                     cyc, tick, round_over, sys_clear, state, secs_left);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.tk !== tick || e.ro !== round_over || e.sc !== sys_clear ||
                e.st !== state || e.secs !== secs_left) begin
               errors++;
               $display("FAIL event got cyc=%0d tick=%b ro=%b sc=%b state=%0d secs=%0d want cyc=%0d tick=%b ro=%b sc=%b state=%0d secs=%0d",
                        cyc, tick, round_over, sys_clear, state, secs_left,
                        e.cyc, e.tk, e.ro, e.sc, e.st, e.secs);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; level = 2'd1; level_reset = 1'b0; start = 1'b0; pause = 1'b0;
      step(3);
      chk("rst_state", int'(state), 0);
      chk("rst_secs", int'(secs_left), 3);
      chk("rst_arm", int'(arm_left), 0);
      chk("rst_pulses", int'({tick, round_active, round_over, sys_clear}), 0);
      rst = 1'b0;
      step(20);
      chk("idle_state", int'(state), 0);
      chk("idle_secs", int'(secs_left), 3);

      // level-1 round with stray starts in ARM and RUN
      start = 1'b1; b = cyc + 1;
      push(b + 12, 1'b1, 1'b0, 1'b0, 2'd2, 6'd2);
      push(b + 16, 1'b1, 1'b0, 1'b0, 2'd2, 6'd1);
      push(b + 20, 1'b1, 1'b1, 1'b0, 2'd3, 6'd0);
      step(1); start = 1'b0;
      chk("arm_state", int'(state), 1);
      chk("arm_left_2", int'(arm_left), 2);
      wait_to(b + 2); start = 1'b1; step(1); start = 1'b0;
      wait_to(b + 4);
      chk("arm_left_1", int'(arm_left), 1);
      wait_to(b + 7);
      chk("arm_left_1_end", int'(arm_left), 1);
      chk("arm_still", int'(state), 1);
      wait_to(b + 8);
      chk("run_state", int'(state), 2);
      chk("run_arm", int'(arm_left), 0);
      chk("run_active", int'(round_active), 1);
      chk("run_secs", int'(secs_left), 3);
      wait_to(b + 10); start = 1'b1; step(1); start = 1'b0;
      wait_to(b + 20);
      chk("done_state", int'(state), 3);
      chk("done_active", int'(round_active), 0);
      wait_to(b + 24);
      chk("done_hold_secs", int'(secs_left), 0);

      // start from DONE, then level_reset to level 3 mid-run
      start = 1'b1; b = cyc + 1;
      push(b + 12, 1'b1, 1'b0, 1'b0, 2'd2, 6'd2);
      push(b + 14, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1);
      step(1); start = 1'b0;
      chk("restart_state", int'(state), 1);
      chk("restart_secs", int'(secs_left), 3);
      wait_to(b + 13); level = 2'd3; level_reset = 1'b1; step(1); level_reset = 1'b0;
      chk("lr_state", int'(state), 0);
      chk("lr_secs", int'(secs_left), 1);
      chk("lr_active", int'(round_active), 0);
      wait_to(b + 24);

      // level_reset exactly on the final terminal suppresses tick and round_over
      start = 1'b1; b = cyc + 1;
      push(b + 12, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1);
      step(1); start = 1'b0;
      wait_to(b + 8);
      chk("l3_run_secs", int'(secs_left), 1);
      wait_to(b + 11); level_reset = 1'b1; step(1); level_reset = 1'b0;
      chk("suppress_state", int'(state), 0);
      wait_to(b + 20);

      // pause freezes the prescaler while it sits at its terminal value
      level = 2'd1; level_reset = 1'b1;
      push(cyc + 1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd3);
      step(1); level_reset = 1'b0;
      start = 1'b1; b = cyc + 1;
      push(b + 12, 1'b1, 1'b0, 1'b0, 2'd2, 6'd2);
      push(b + 26, 1'b1, 1'b0, 1'b0, 2'd2, 6'd1);
      push(b + 30, 1'b1, 1'b1, 1'b0, 2'd3, 6'd0);
      step(1); start = 1'b0;
      wait_to(b + 15); pause = 1'b1;
      wait_to(b + 20);
      chk("pause_secs", int'(secs_left), 2);
      chk("pause_state", int'(state), 2);
      wait_to(b + 25); pause = 1'b0;
      wait_to(b + 31);
      chk("pause_done", int'(state), 3);

      // level_reset beats start in the same cycle
      level = 2'd3; level_reset = 1'b1;
      push(cyc + 1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd1);
      step(1); level_reset = 1'b0;
      level = 2'd2; level_reset = 1'b1; start = 1'b1;
      push(cyc + 1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd2);
      step(1); level_reset = 1'b0; start = 1'b0;
      chk("lr_start_state", int'(state), 0);
      chk("lr_start_secs", int'(secs_left), 2);
      step(3);
      chk("lr_start_hold", int'(state), 0);

      // level 0 maps to level 1
      level = 2'd0; level_reset = 1'b1;
      push(cyc + 1, 1'b0, 1'b0, 1'b1, 2'd0, 6'd3);
      step(1); level_reset = 1'b0;
      chk("lvl0_secs", int'(secs_left), 3);
      start = 1'b1; b = cyc + 1; step(1); start = 1'b0;
      chk("lvl0_arm", int'(state), 1);
      chk("lvl0_arm_secs", int'(secs_left), 3);
      wait_to(b + 9);
      chk("lvl0_run", int'(state), 2);

      // asynchronous reset mid-run
      rst = 1'b1; #1;
      chk("async_state", int'(state), 0);
      chk("async_secs", int'(secs_left), 3);
      chk("async_active", int'(round_active), 0);
      step(2); rst = 1'b0;
      step(5);
      chk("pending_events", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/level_round_timer.md
Name: level_round_timer

Overview:
- Consumer end of the level-selection interface: takes the selected level (1-3) and the one-cycle level-change pulse.
- Runs the per-level round sequence: idle, armed countdown, timed run, done.
- Outputs the remaining seconds, a per-second tick, a round-over pulse, and a system-clear pulse used to reset score and other game logic.
- Sits between level selection and the scoring/display blocks.

Parameters:
- CLKS_PER_TICK, 50000000, clocks per one-second tick (1 s at 50 MHz); must be >= 2.
- L1_SECS, 30, round length in seconds for level 1; range 1-63.
- L2_SECS, 20, round length in seconds for level 2; range 1-63.
- L3_SECS, 10, round length in seconds for level 3; range 1-63.
- ARM_TICKS, 3, pre-round countdown in ticks; range 0-3.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, global reset; asynchronous, active-high.
- level, input, 2, selected level: 1, 2 or 3. Value 0 is treated as 1.
- level_reset, input, 1, one-cycle pulse that latches level and aborts the current round.
- start, input, 1, one-cycle pulse (already debounced) that begins a round.
- pause, input, 1, level signal; while high, the prescaler is frozen in ARM and RUN.
- state, output, 2, current state: 0 IDLE, 1 ARM, 2 RUN, 3 DONE.
- secs_left, output, 6, seconds remaining in the round.
- arm_left, output, 2, countdown ticks remaining while in ARM; 0 in all other states.
- tick, output, 1, one-cycle pulse on each second boundary in RUN.
- round_active, output, 1, high only while in RUN.
- round_over, output, 1, one-cycle pulse when the round expires.
- sys_clear, output, 1, one-cycle pulse one cycle after level_reset is accepted.

Behaviour:
- Reset (asynchronous, rst high): state=IDLE, latched level=1, secs_left=L1_SECS, arm_left=0, prescaler=0. tick, round_active, round_over and sys_clear are all 0.
- All outputs are registered.
- limit(L) = L1_SECS, L2_SECS or L3_SECS; level 0 maps to L1_SECS.
- The prescaler counts 0 to CLKS_PER_TICK-1. A "terminal" is the cycle in which it equals CLKS_PER_TICK-1 and pause=0. It wraps to 0 on terminal. It holds its value while pause=1.
- Priority is level_reset > start > tick processing.
- level_reset, accepted in any state:
  - latch level;
  - state <- IDLE, secs_left <- limit(new level), arm_left <- 0, prescaler <- 0;
  - sys_clear=1 on the following cycle;
  - a round_over or tick that would have fired in the same cycle is suppressed.
- level changes without a level_reset pulse are ignored.
- IDLE or DONE, on start:
  - secs_left <- limit(latched level), prescaler <- 0;
  - if ARM_TICKS > 0: state <- ARM, arm_left <- ARM_TICKS;
  - if ARM_TICKS = 0: state <- RUN directly.
- start is ignored in ARM and RUN.
- ARM, on terminal:
  - arm_left decrements;
  - if arm_left was 1: state <- RUN, arm_left <- 0, prescaler <- 0.
  - tick does not fire in ARM.
- RUN, on terminal:
  - tick=1 on the next cycle;
  - secs_left decrements;
  - if secs_left was 1: secs_left <- 0, state <- DONE, and round_over=1 on the same cycle that tick=1.
- round_active = (state == RUN), registered together with state.
- DONE holds secs_left=0 until a start or level_reset arrives.
- Mid-operation rst aborts immediately to the reset values listed above.
- secs_left never wraps below 0.

Test Plan (CLKS_PER_TICK=4, L1_SECS=3, L2_SECS=2, L3_SECS=1, ARM_TICKS=2):
- Reset, then idle for 20 cycles -> state=0, secs_left=3, and tick, round_over, sys_clear never assert.
- Level-1 round: start at cycle 0 -> ARM with arm_left=2,1, then RUN after 8 clocks. In RUN, 3 ticks at 4-clock spacing with secs_left=2,1,0. round_over coincides with the third tick, then state=3 and round_active=0.
- level=3 with level_reset during RUN with secs_left=2 -> next cycle state=0, secs_left=1, sys_clear=1 for exactly one cycle, no round_over.
- pause held high for 10 cycles in RUN -> secs_left and the prescaler are frozen. After release, the next tick arrives after the remaining prescaler count.
- start asserted during ARM and RUN -> ignored, and timing is unchanged. start in DONE -> secs_left reloads to limit(level) and state=ARM.
- level_reset and start in the same cycle while in IDLE with level=2 -> state stays 0, secs_left=2, sys_clear pulses once. A later start with level input=0 and a level_reset -> secs_left=3.
